// File: rtl/exec_pkg.sv
// Shared definitions for the execution controller: FSM state type and a
// helper that sizes counters from their terminal counts.
package exec_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2,
        CLEAR = 2'd3
    } state_t;

    // Bits needed to hold values 0..n
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchronizer plus debounce counter; toggle pulses for one cycle
// in the cycle the debounced level changes.
module sw_debounce
    import exec_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 100000
) (
    input  logic clk_in,
    input  logic reset,
    input  logic sw,
    output logic level,
    output logic toggle
);

    localparam int unsigned CW = cnt_width(DEB_CYCLES);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            level  <= 1'b0;
            toggle <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1  <= sw;
            sync2  <= sync1;
            toggle <= 1'b0;
            // Accept the new level only after an unbroken run of mismatches
            if (sync2 != level) begin
                if (cnt == CW'(DEB_CYCLES - 1)) begin
                    level  <= sync2;
                    toggle <= 1'b1;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/exec_ctrl.sv
// Execution controller: debounced switches drive a halt/run/step/clear FSM
// that issues single-cycle CPU enables and a timed CPU clear.
module exec_ctrl
    import exec_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 100000,
    parameter int unsigned SLOW_DIV   = 50000000,
    parameter int unsigned FAST_DIV   = 5000000,
    parameter int unsigned CLR_CYCLES = 2
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       sw_run,
    input  logic       sw_step,
    input  logic       sw_fast,
    input  logic       sw_clr,
    input  logic       halt_in,
    output logic       cpu_en,
    output logic       cpu_clr,
    output logic [1:0] mode,
    output logic       halted
);

    localparam int unsigned MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
    localparam int unsigned PW      = cnt_width(MAX_DIV);
    localparam int unsigned CLW     = cnt_width(CLR_CYCLES);

    // Switch index: 0 run, 1 step, 2 fast, 3 clr
    logic [3:0] sw_raw;
    logic [3:0] sw_lvl;
    logic [3:0] sw_tog;

    assign sw_raw = {sw_clr, sw_fast, sw_step, sw_run};

    for (genvar g = 0; g < 4; g++) begin : g_deb
        sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk_in (clk_in),
            .reset  (reset),
            .sw     (sw_raw[g]),
            .level  (sw_lvl[g]),
            .toggle (sw_tog[g])
        );
    end

    logic run_rise;
    logic step_rise;
    logic clr_rise;
    logic fast_chg;

    assign run_rise  = sw_tog[0] & sw_lvl[0];
    assign step_rise = sw_tog[1] & sw_lvl[1];
    assign fast_chg  = sw_tog[2];
    assign clr_rise  = sw_tog[3] & sw_lvl[3];

    state_t         state;
    state_t         state_n;
    logic           cpu_en_n;
    logic           cpu_clr_n;
    logic           halted_n;
    logic [PW-1:0]  pre_cnt;
    logic [PW-1:0]  div_m1;
    logic [CLW-1:0] clr_cnt;
    logic           tick;
    logic           clr_done;

    assign div_m1   = sw_lvl[2] ? PW'(FAST_DIV - 1) : PW'(SLOW_DIV - 1);
    assign tick     = (state == RUN) && (pre_cnt == div_m1) && !fast_chg;
    assign clr_done = (clr_cnt == CLW'(CLR_CYCLES - 1));
    assign mode     = state;

    // Prescaler only advances in RUN; a speed change restarts the period
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if ((state != RUN) || fast_chg || tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            clr_cnt <= '0;
        end else if (state != CLEAR) begin
            clr_cnt <= '0;
        end else begin
            clr_cnt <= clr_cnt + CLW'(1);
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cpu_en  <= 1'b0;
            cpu_clr <= 1'b0;
            halted  <= 1'b0;
        end else begin
            state   <= state_n;
            cpu_en  <= cpu_en_n;
            cpu_clr <= cpu_clr_n;
            halted  <= halted_n;
        end
    end

    // Next-state and next-output decode; leaving RUN swallows a coinciding tick
    always_comb begin
        state_n   = state;
        cpu_en_n  = 1'b0;
        cpu_clr_n = 1'b0;
        halted_n  = halted;
        case (state)
            IDLE: begin
                if (clr_rise) begin
                    state_n   = CLEAR;
                    cpu_clr_n = 1'b1;
                end else if (run_rise) begin
                    state_n  = RUN;
                    halted_n = 1'b0;
                end else if (step_rise) begin
                    state_n  = STEP;
                    cpu_en_n = 1'b1;
                end
            end
            RUN: begin
                if (clr_rise) begin
                    state_n   = CLEAR;
                    cpu_clr_n = 1'b1;
                end else if (!sw_lvl[0]) begin
                    state_n = IDLE;
                end else if (halt_in) begin
                    state_n  = IDLE;
                    halted_n = 1'b1;
                end else if (tick) begin
                    cpu_en_n = 1'b1;
                end
            end
            STEP: begin
                state_n = IDLE;
            end
            CLEAR: begin
                halted_n = 1'b0;
                if (clr_done) begin
                    state_n = IDLE;
                end else begin
                    cpu_clr_n = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed bench for exec_ctrl with short debounce/divider settings.
module tb_exec_ctrl;

    logic       clk_in  = 1'b0;
    logic       reset   = 1'b1;
    logic       sw_run  = 1'b0;
    logic       sw_step = 1'b0;
    logic       sw_fast = 1'b0;
    logic       sw_clr  = 1'b0;
    logic       halt_in = 1'b0;
    logic       cpu_en;
    logic       cpu_clr;
    logic [1:0] mode;
    logic       halted;

    int tests = 0;
    int fails = 0;

    int n_en, first_en, last_en, n_clr, first_clr, n_both, n_busy, en_mode;

    exec_ctrl #(
        .DEB_CYCLES (4),
        .SLOW_DIV   (8),
        .FAST_DIV   (2),
        .CLR_CYCLES (2)
    ) dut (
        .clk_in  (clk_in),
        .reset   (reset),
        .sw_run  (sw_run),
        .sw_step (sw_step),
        .sw_fast (sw_fast),
        .sw_clr  (sw_clr),
        .halt_in (halt_in),
        .cpu_en  (cpu_en),
        .cpu_clr (cpu_clr),
        .mode    (mode),
        .halted  (halted)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    // Step n cycles, recording enable/clear pulse positions (1-based)
    task automatic watch(input int n);
        n_en = 0; first_en = 0; last_en = 0;
        n_clr = 0; first_clr = 0; n_both = 0; n_busy = 0; en_mode = -1;
        for (int i = 1; i <= n; i++) begin
            cyc();
            if (cpu_en === 1'b1) begin
                n_en++;
                if (first_en == 0) begin
                    first_en = i;
                    en_mode  = int'(mode);
                end
                last_en = i;
            end
            if (cpu_clr === 1'b1) begin
                n_clr++;
                if (first_clr == 0) first_clr = i;
            end
            if (cpu_en === 1'b1 && cpu_clr === 1'b1) n_both++;
            if (mode !== 2'd0) n_busy++;
        end
    endtask

    initial begin
        // Reset state
        cyc(); cyc();
        chk("rst_en",     32'(cpu_en),  0);
        chk("rst_clr",    32'(cpu_clr), 0);
        chk("rst_mode",   32'(mode),    0);
        chk("rst_halted", 32'(halted),  0);
        reset = 1'b0;
        watch(50);
        chk("idle_en",   32'(n_en),   0);
        chk("idle_busy", 32'(n_busy), 0);

        // Single step
        sw_step = 1'b1;
        watch(10);
        chk("step_count", 32'(n_en),     1);
        chk("step_lat",   32'(first_en), 7);
        chk("step_mode",  32'(en_mode),  2);
        sw_step = 1'b0;
        watch(12);
        chk("step_release", 32'(n_en), 0);

        // Glitch shorter than the debounce window
        sw_step = 1'b1;
        watch(2);
        chk("glitch_a", 32'(n_en), 0);
        sw_step = 1'b0;
        watch(12);
        chk("glitch_b", 32'(n_en), 0);

        // Slow run
        sw_run = 1'b1;
        watch(40);
        chk("slow_count", 32'(n_en),     4);
        chk("slow_first", 32'(first_en), 15);
        chk("slow_last",  32'(last_en),  39);
        chk("slow_mode",  32'(en_mode),  1);

        // Fast run after speed change
        sw_fast = 1'b1;
        watch(16);
        chk("fast_count", 32'(n_en),     4);
        chk("fast_first", 32'(first_en), 9);
        chk("fast_last",  32'(last_en),  15);

        // Run switch low stops pulses
        sw_run  = 1'b0;
        sw_fast = 1'b0;
        watch(12);
        chk("stop_count", 32'(n_en),    3);
        chk("stop_last",  32'(last_en), 5);
        chk("stop_mode",  32'(mode),    0);

        // Halt from CPU
        sw_run = 1'b1;
        watch(16);
        chk("halt_pre", 32'(n_en), 1);
        halt_in = 1'b1;
        watch(20);
        chk("halt_en",     32'(n_en),   0);
        chk("halt_flag",   32'(halted), 1);
        chk("halt_mode",   32'(mode),   0);
        halt_in = 1'b0;
        sw_run  = 1'b0;
        watch(8);
        chk("halt_sticky", 32'(halted), 1);
        sw_run = 1'b1;
        watch(8);
        chk("resume_mode",   32'(mode),   1);
        chk("resume_halted", 32'(halted), 0);

        // Clear in RUN, coinciding with a prescaler tick
        sw_clr = 1'b1;
        watch(20);
        chk("clr_len",   32'(n_clr),     2);
        chk("clr_first", 32'(first_clr), 7);
        chk("clr_en",    32'(n_en),      0);
        chk("clr_both",  32'(n_both),    0);
        chk("clr_mode",  32'(mode),      0);
        sw_clr = 1'b0;

        // Asynchronous reset in the middle of an enable pulse
        sw_run = 1'b0;
        watch(8);
        sw_run = 1'b1;
        watch(15);
        chk("pre_rst_first", 32'(first_en), 15);
        chk("pre_rst_en",    32'(cpu_en),   1);
        reset = 1'b1;
        #1;
        chk("arst_en",   32'(cpu_en),  0);
        chk("arst_mode", 32'(mode),    0);
        chk("arst_clr",  32'(cpu_clr), 0);
        cyc(); cyc();
        reset = 1'b0;
        watch(6);
        chk("rerun_wait", 32'(n_busy), 0);
        watch(1);
        chk("rerun_mode", 32'(mode), 1);
        watch(8);
        chk("rerun_count", 32'(n_en),     1);
        chk("rerun_first", 32'(first_en), 8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
